// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   - SEG_* constants: segment patterns in {G,F,E,D,C,B,A} order, active-high.
//   - seg_decode(): BCD code to 7-segment pattern.
//   - scan_state_t: scan slot phase (blanking gap or digit lit).
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3f;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5b;
    localparam logic [6:0] SEG_3     = 7'h4f;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6d;
    localparam logic [6:0] SEG_6     = 7'h7d;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7f;
    localparam logic [6:0] SEG_9     = 7'h6f;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // 4'hE renders as a dash; the remaining non-decimal codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (bcd)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hE: seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_decode_lut.sv
// Combinational BCD to 7-segment lookup.
//   bcd : input  [3:0]  digit code
//   seg : output [6:0]  {G,F,E,D,C,B,A}, active-high
module seg_decode_lut
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_decode(bcd);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS 7-segment digits sharing
// one segment bus. Frames of digit codes are written into a shadow buffer
// and copied to the displayed (active) buffer only at a frame boundary, so
// a frame never tears. Each digit slot starts with an all-off blanking gap
// to suppress ghosting, then lights the digit for DWELL_CYCLES.
//
// Ports:
//   clk_in     : system clock
//   rst_in     : asynchronous reset, active-high
//   wr_valid   : writer offers a frame (wr_code / wr_dp)
//   wr_ready   : shadow buffer free; a frame is taken on wr_valid && wr_ready
//   wr_code    : 4-bit code per digit, digit i = [4i+3:4i]
//   wr_dp      : decimal point per digit
//   digit_en   : live per-digit enable, not buffered
//   seg_out    : {DP,G,F,E,D,C,B,A}, active-high, registered
//   dig_sel    : digit selects, asserted level set by DIG_ACTIVE_LOW, registered
//   frame_tick : one-cycle pulse in the last lit cycle of the last digit
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int DWELL_CYCLES   = 12000,
    parameter int BLANK_CYCLES   = 120,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4*NUM_DIGITS-1:0]   wr_code,
    input  logic [NUM_DIGITS-1:0]     wr_dp,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    // XOR mask turning an active-high select vector into the pin polarity.
    localparam logic [NUM_DIGITS-1:0] SEL_MASK   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    scan_state_t               state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [IDX_W-1:0]          idx_reg, idx_next;

    logic [4*NUM_DIGITS-1:0]   shadow_code_reg, active_code_reg;
    logic [NUM_DIGITS-1:0]     shadow_dp_reg, active_dp_reg;
    logic                      pending_reg;

    logic [7:0]                seg_out_reg;
    logic [NUM_DIGITS-1:0]     dig_sel_reg;
    logic                      frame_tick_reg;

    logic                      accept;
    logic                      boundary;
    logic [3:0]                active_digit [NUM_DIGITS];
    logic [3:0]                show_code;
    logic [6:0]                show_seg;
    logic                      lit_next;
    logic [NUM_DIGITS-1:0]     sel_next;
    logic [7:0]                seg_next;
    logic                      frame_tick_next;

    assign wr_ready   = ~pending_reg;
    assign accept     = wr_valid && ~pending_reg;
    assign boundary   = (state_reg == ST_SHOW) && (idx_reg == IDX_LAST) && (cnt_reg == '0);

    assign seg_out    = seg_out_reg;
    assign dig_sel    = dig_sel_reg;
    assign frame_tick = frame_tick_reg;

    // Slot sequencer: each state runs for its length, counting down to 0.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end else begin
            case (state_reg)
                ST_BLANK: begin
                    state_next = ST_SHOW;
                    cnt_next   = DWELL_LAST;
                end
                ST_SHOW: begin
                    state_next = ST_BLANK;
                    cnt_next   = BLANK_LAST;
                    idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                end
                default: begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign active_digit[gi] = active_code_reg[4*gi +: 4];
            assign sel_next[gi]     = lit_next && (idx_next == IDX_W'(gi));
        end
    endgenerate

    // Outputs are computed from the next slot state so the output registers
    // change on the same edge the state is entered. A lit digit never starts
    // on the commit edge (a blanking gap always follows the boundary), so the
    // current active buffer is the right source here.
    assign show_code = active_digit[idx_next];

    seg_decode_lut u_decode (
        .bcd (show_code),
        .seg (show_seg)
    );

    assign lit_next        = (state_next == ST_SHOW) && digit_en[idx_next];
    assign seg_next        = lit_next ? {active_dp_reg[idx_next], show_seg} : 8'h00;
    assign frame_tick_next = (state_next == ST_SHOW) && (idx_next == IDX_LAST) && (cnt_next == '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg       <= ST_BLANK;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            shadow_code_reg <= '0;
            shadow_dp_reg   <= '0;
            active_code_reg <= '0;
            active_dp_reg   <= '0;
            pending_reg     <= 1'b0;
            seg_out_reg     <= 8'h00;
            dig_sel_reg     <= SEL_MASK;
            frame_tick_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            seg_out_reg    <= seg_next;
            dig_sel_reg    <= sel_next ^ SEL_MASK;
            frame_tick_reg <= frame_tick_next;

            // Accept and commit are exclusive: accept needs pending clear,
            // commit needs it set.
            if (accept) begin
                shadow_code_reg <= wr_code;
                shadow_dp_reg   <= wr_dp;
                pending_reg     <= 1'b1;
            end else if (boundary && pending_reg) begin
                active_code_reg <= shadow_code_reg;
                active_dp_reg   <= shadow_dp_reg;
                pending_reg     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (2 digits, dwell 4, blank 1,
// active-low selects). A reference model tracks the position inside the
// frame and the writer buffers; expected outputs are derived from the
// position with plain arithmetic.
module tb_seg_scan_ctrl;

    localparam int ND    = 2;
    localparam int DW    = 4;
    localparam int BL    = 1;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = ND * SLOT;

    logic         clk_in   = 1'b0;
    logic         rst_in   = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [7:0]   wr_code  = 8'h00;
    logic [1:0]   wr_dp    = 2'b00;
    logic [1:0]   digit_en = 2'b11;
    logic [7:0]   seg_out;
    logic [1:0]   dig_sel;
    logic         frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .DWELL_CYCLES   (DW),
        .BLANK_CYCLES   (BL),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_code    (wr_code),
        .wr_dp      (wr_dp),
        .digit_en   (digit_en),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk_in = ~clk_in;

    // Segment patterns {G..A} for codes 0..F.
    logic [6:0] seg_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                 7'h7f, 7'h6f, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00};

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state.
    int         m_pos;
    int         m_accepts = 0;
    logic       m_pending;
    logic [7:0] m_sh_code, m_act_code;
    logic [1:0] m_sh_dp, m_act_dp;
    logic [1:0] m_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, pos %0d)", tag, got, exp, $time, m_pos);
    endtask

    task automatic model_reset();
        m_pos      = 0;
        m_pending  = 1'b0;
        m_sh_code  = 8'h00;
        m_act_code = 8'h00;
        m_sh_dp    = 2'b00;
        m_act_dp   = 2'b00;
        m_en       = 2'b00;
    endtask

    // Applies the inputs sampled at a rising edge and advances one cycle.
    task automatic model_edge();
        bit is_boundary;
        is_boundary = (m_pos == FRAME - 1);
        if (wr_valid && !m_pending) begin
            m_sh_code = wr_code;
            m_sh_dp   = wr_dp;
            m_pending = 1'b1;
            m_accepts++;
            $display("accept frame code=%h dp=%b at frame pos %0d", wr_code, wr_dp, m_pos);
        end else if (is_boundary && m_pending) begin
            m_act_code = m_sh_code;
            m_act_dp   = m_sh_dp;
            m_pending  = 1'b0;
        end
        m_en  = digit_en;
        m_pos = (m_pos + 1) % FRAME;
    endtask

    task automatic check_outputs();
        int         slot;
        int         off;
        bit         lit;
        logic [1:0] exp_sel;
        logic [7:0] exp_seg;
        logic [3:0] code;
        slot    = m_pos / SLOT;
        off     = m_pos % SLOT;
        lit     = (off >= BL) && m_en[slot];
        exp_sel = 2'b11;
        exp_seg = 8'h00;
        code    = m_act_code[4*slot +: 4];
        if (lit) begin
            exp_sel[slot] = 1'b0;
            exp_seg       = {m_act_dp[slot], seg_tab[code]};
        end
        check_eq("dig_sel",    32'(dig_sel),    32'(exp_sel));
        check_eq("seg_out",    32'(seg_out),    32'(exp_seg));
        check_eq("frame_tick", 32'(frame_tick), 32'(m_pos == FRAME - 1));
        check_eq("wr_ready",   32'(wr_ready),   32'(!m_pending));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_seg"},   32'(seg_out),    32'h00);
        check_eq({tag, "_sel"},   32'(dig_sel),    32'h3);
        check_eq({tag, "_tick"},  32'(frame_tick), 32'h0);
        check_eq({tag, "_ready"}, 32'(wr_ready),   32'h1);
    endtask

    // Called just after a rising edge; asserts reset, holds it, releases it.
    task automatic apply_reset(input int hold);
        wr_valid = 1'b0;
        rst_in   = 1'b1;
        #1;
        check_reset_values("rst_async");
        repeat (hold) @(posedge clk_in);
        #1;
        check_reset_values("rst_hold");
        rst_in = 1'b0;
        model_reset();
        check_outputs();
    endtask

    task automatic write_frame(input logic [7:0] code, input logic [1:0] dp);
        wr_valid = 1'b1;
        wr_code  = code;
        wr_dp    = dp;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        int n;
        n = 0;
        while (m_pos != pos && n < 2 * FRAME) begin
            step();
            n++;
        end
    endtask

    initial begin
        int acc0;
        model_reset();

        // Reset state, then free-running display of the reset codes.
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_values("reset");
        rst_in = 1'b0;
        check_outputs();
        run(2 * FRAME);

        // Single write mid-frame: held off until the boundary, shown after.
        wait_pos(3);
        write_frame(8'h93, 2'b01);
        run(2 * FRAME);

        // Writer holds valid while a frame is pending.
        wait_pos(2);
        write_frame(8'h21, 2'b10);
        wr_valid = 1'b1;
        wr_code  = 8'h45;
        wr_dp    = 2'b00;
        acc0     = m_accepts;
        for (int i = 0; i < 2 * FRAME && m_accepts == acc0; i++) step();
        check_eq("held_accept", 32'(m_accepts - acc0), 32'd1);
        wr_valid = 1'b0;
        run(2 * FRAME);

        // Digit 0 disabled: its slot keeps timing but stays dark.
        digit_en = 2'b10;
        run(2 * FRAME);
        digit_en = 2'b11;

        // Dash and blank codes.
        write_frame(8'hBE, 2'b00);
        run(3 * FRAME);

        // Reset while digit 1 is lit and a frame is pending.
        wait_pos(1);
        write_frame(8'h77, 2'b11);
        wait_pos(SLOT + BL + 1);
        apply_reset(2);
        run(2 * FRAME);

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 500; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_code  = 8'($urandom);
            wr_dp    = 2'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = 2'($urandom);
            if (i == 250) apply_reset(1);
            else step();
        end
        wr_valid = 1'b0;
        run(FRAME);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
